// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// N-stage instruction sequencer for the multicycle RV32I core. Walks a one-hot
// stage enable from stage 0 (fetch) to stage NUM_STAGES-1 (retire). Each stage
// is held until its ready bit is seen. Also provides run/halt control at
// instruction boundaries, a PC-redirect flush, a per-stage watchdog and a
// retired-instruction counter.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   run_i          1 = keep sequencing; 0 = halt at the next retirement
//   stage_rdy_i    per-stage completion; only the active stage's bit matters
//   flush_i        abort the current instruction, restart at stage 0
//   stage_o        active stage index (0 when halted / in error)
//   stage_en_o     one-hot active-stage enable (0 when halted / in error)
//   stage_first_o  high in the first cycle of every stage entry
//   retire_o       combinational retire pulse (last stage, rdy, no flush)
//   retire_cnt_o   wrapping retired-instruction count
//   wait_cnt_o     cycles spent in the current stage without rdy (saturating)
//   halted_o       high in HALT or ERR
//   timeout_o      sticky watchdog error, cleared only by reset
// -----------------------------------------------------------------------------
module stage_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int STG_W      = 3,
    parameter int MAX_WAIT   = 15,
    parameter int RET_CNT_W  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  run_i,
    input  logic [NUM_STAGES-1:0] stage_rdy_i,
    input  logic                  flush_i,
    output logic [STG_W-1:0]      stage_o,
    output logic [NUM_STAGES-1:0] stage_en_o,
    output logic                  stage_first_o,
    output logic                  retire_o,
    output logic [RET_CNT_W-1:0]  retire_cnt_o,
    output logic [7:0]            wait_cnt_o,
    output logic                  halted_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t                state_reg;
    logic [STG_W-1:0]      stage_reg;
    logic [NUM_STAGES-1:0] stage_en_reg;
    logic                  first_reg;
    logic [7:0]            wait_reg;
    logic [RET_CNT_W-1:0]  retire_cnt_reg;
    logic                  halted_reg;
    logic                  timeout_reg;

    // Ready of the active stage only. Masking with the one-hot enable avoids a
    // variable bit-select and guarantees inactive rdy bits are ignored. The
    // enable is all-zero outside RUN, so rdy_masked is zero there as well.
    logic [NUM_STAGES-1:0] rdy_masked;
    logic                  rdy_cur;
    logic                  at_last;
    logic                  wd_expired;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_rdy_mask
            assign rdy_masked[gi] = stage_rdy_i[gi] & stage_en_reg[gi];
        end
    endgenerate

    assign rdy_cur    = |rdy_masked;
    assign at_last    = stage_en_reg[NUM_STAGES-1];
    // A watchdog limit of zero means "never time out".
    assign wd_expired = (MAX_WAIT != 0) && (wait_reg == 8'(MAX_WAIT));

    // The only combinational output: flush wins over a simultaneous retire.
    assign retire_o = (state_reg == ST_RUN) && at_last && rdy_cur && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= ST_HALT;
            stage_reg      <= '0;
            stage_en_reg   <= '0;
            first_reg      <= 1'b0;
            wait_reg       <= '0;
            retire_cnt_reg <= '0;
            halted_reg     <= 1'b1;
            timeout_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_HALT: begin
                    if (run_i) begin
                        state_reg    <= ST_RUN;
                        stage_reg    <= '0;
                        stage_en_reg <= NUM_STAGES'(1);
                        first_reg    <= 1'b1;
                        wait_reg     <= '0;
                        halted_reg   <= 1'b0;
                    end else begin
                        first_reg    <= 1'b0;
                    end
                end

                ST_RUN: begin
                    first_reg <= 1'b0;
                    if (flush_i || (rdy_cur && at_last)) begin
                        // Instruction boundary (aborted or retired): restart
                        // at fetch, or park in HALT if run has been dropped.
                        wait_reg  <= '0;
                        stage_reg <= '0;
                        if (!flush_i) begin
                            retire_cnt_reg <= retire_cnt_reg + RET_CNT_W'(1);
                        end
                        if (run_i) begin
                            stage_en_reg <= NUM_STAGES'(1);
                            first_reg    <= 1'b1;
                        end else begin
                            state_reg    <= ST_HALT;
                            stage_en_reg <= '0;
                            halted_reg   <= 1'b1;
                        end
                    end else if (rdy_cur) begin
                        stage_reg    <= stage_reg + STG_W'(1);
                        stage_en_reg <= stage_en_reg << 1;
                        first_reg    <= 1'b1;
                        wait_reg     <= '0;
                    end else if (wd_expired) begin
                        state_reg    <= ST_ERR;
                        stage_reg    <= '0;
                        stage_en_reg <= '0;
                        wait_reg     <= '0;
                        halted_reg   <= 1'b1;
                        timeout_reg  <= 1'b1;
                    end else if (wait_reg != 8'hFF) begin
                        wait_reg <= wait_reg + 8'd1;
                    end
                end

                ST_ERR: begin
                    // Locked until reset; all inputs are ignored.
                    first_reg <= 1'b0;
                end

                default: begin
                    state_reg    <= ST_ERR;
                    stage_reg    <= '0;
                    stage_en_reg <= '0;
                    first_reg    <= 1'b0;
                    halted_reg   <= 1'b1;
                    timeout_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign stage_o       = stage_reg;
    assign stage_en_o    = stage_en_reg;
    assign stage_first_o = first_reg;
    assign retire_cnt_o  = retire_cnt_reg;
    assign wait_cnt_o    = wait_reg;
    assign halted_o      = halted_reg;
    assign timeout_o     = timeout_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// Self-checking bench for stage_sequencer (NUM_STAGES=4, MAX_WAIT=15,
// RET_CNT_W=4). Every cycle the inputs are driven, a reference model predicts
// the next-cycle registered outputs and pushes them onto a scoreboard queue;
// after the clock edge the entry is popped and compared. retire_o is checked
// combinationally before the edge.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    localparam int N  = 4;
    localparam int SW = 3;
    localparam int MW = 15;
    localparam int RW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          run_i;
    logic [N-1:0]  stage_rdy_i;
    logic          flush_i;
    logic [SW-1:0] stage_o;
    logic [N-1:0]  stage_en_o;
    logic          stage_first_o;
    logic          retire_o;
    logic [RW-1:0] retire_cnt_o;
    logic [7:0]    wait_cnt_o;
    logic          halted_o;
    logic          timeout_o;

    stage_sequencer #(
        .NUM_STAGES (N),
        .STG_W      (SW),
        .MAX_WAIT   (MW),
        .RET_CNT_W  (RW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .run_i         (run_i),
        .stage_rdy_i   (stage_rdy_i),
        .flush_i       (flush_i),
        .stage_o       (stage_o),
        .stage_en_o    (stage_en_o),
        .stage_first_o (stage_first_o),
        .retire_o      (retire_o),
        .retire_cnt_o  (retire_cnt_o),
        .wait_cnt_o    (wait_cnt_o),
        .halted_o      (halted_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_ERR  = 2;

    int m_state;
    int m_s;
    int m_wait;
    int m_cnt;
    bit m_first;

    typedef struct packed {
        logic [SW-1:0] stage;
        logic [N-1:0]  en;
        logic          first;
        logic [RW-1:0] cnt;
        logic [7:0]    wt;
        logic          halted;
        logic          tmo;
    } exp_t;

    exp_t sb[$];

    task automatic model_reset();
        m_state = M_HALT;
        m_s     = 0;
        m_wait  = 0;
        m_cnt   = 0;
        m_first = 1'b0;
        sb.delete();
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.stage  = (m_state == M_RUN) ? SW'(m_s) : '0;
        e.en     = (m_state == M_RUN) ? N'(1 << m_s) : '0;
        e.first  = m_first;
        e.cnt    = RW'(m_cnt);
        e.wt     = 8'(m_wait);
        e.halted = (m_state != M_RUN);
        e.tmo    = (m_state == M_ERR);
        return e;
    endfunction

    function automatic bit model_retire(input bit flush, input logic [N-1:0] rdy);
        return (m_state == M_RUN) && (m_s == N - 1) && (rdy[m_s] == 1'b1) && !flush;
    endfunction

    task automatic model_step(input bit run, input logic [N-1:0] rdy, input bit flush);
        if (m_state == M_HALT) begin
            if (run) begin
                m_state = M_RUN;
                m_s     = 0;
                m_wait  = 0;
                m_first = 1'b1;
            end else begin
                m_first = 1'b0;
            end
        end else if (m_state == M_RUN) begin
            m_first = 1'b0;
            if (flush || (rdy[m_s] && m_s == N - 1)) begin
                if (!flush) m_cnt = (m_cnt + 1) % (1 << RW);
                m_wait = 0;
                m_s    = 0;
                if (run) m_first = 1'b1;
                else     m_state = M_HALT;
            end else if (rdy[m_s]) begin
                m_s     = m_s + 1;
                m_wait  = 0;
                m_first = 1'b1;
            end else if (MW != 0 && m_wait == MW) begin
                m_state = M_ERR;
                m_s     = 0;
                m_wait  = 0;
            end else if (m_wait < 255) begin
                m_wait = m_wait + 1;
            end
        end else begin
            m_first = 1'b0;
        end
    endtask

    // One transaction = one clock cycle with the given inputs.
    task automatic step(input bit run, input logic [N-1:0] rdy, input bit flush);
        exp_t e;
        run_i       = run;
        stage_rdy_i = rdy;
        flush_i     = flush;
        #1;
        check("retire_o", 32'(retire_o), 32'(model_retire(flush, rdy)));
        model_step(run, rdy, flush);
        sb.push_back(model_out());
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        check("stage_o",       32'(stage_o),       32'(e.stage));
        check("stage_en_o",    32'(stage_en_o),    32'(e.en));
        check("stage_first_o", 32'(stage_first_o), 32'(e.first));
        check("retire_cnt_o",  32'(retire_cnt_o),  32'(e.cnt));
        check("wait_cnt_o",    32'(wait_cnt_o),    32'(e.wt));
        check("halted_o",      32'(halted_o),      32'(e.halted));
        check("timeout_o",     32'(timeout_o),     32'(e.tmo));
        $display("t=%0t run=%b rdy=%b flush=%b -> stage=%0d en=%b first=%b cnt=%0d wait=%0d halted=%b tmo=%b",
                 $time, run, rdy, flush, stage_o, stage_en_o, stage_first_o,
                 retire_cnt_o, wait_cnt_o, halted_o, timeout_o);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".stage_o"},       32'(stage_o),       32'd0);
        check({tag, ".stage_en_o"},    32'(stage_en_o),    32'd0);
        check({tag, ".stage_first_o"}, 32'(stage_first_o), 32'd0);
        check({tag, ".retire_o"},      32'(retire_o),      32'd0);
        check({tag, ".retire_cnt_o"},  32'(retire_cnt_o),  32'd0);
        check({tag, ".wait_cnt_o"},    32'(wait_cnt_o),    32'd0);
        check({tag, ".halted_o"},      32'(halted_o),      32'd1);
        check({tag, ".timeout_o"},     32'(timeout_o),     32'd0);
    endtask

    // Reset asserted mid-cycle; released mid-cycle one edge later.
    task automatic do_reset();
        rst_i       = 1'b1;
        run_i       = 1'b0;
        flush_i     = 1'b0;
        stage_rdy_i = '1;
        #1;
        check_reset_values("rst_async");
        @(posedge clk_i);
        #1;
        check_reset_values("rst_held");
        rst_i = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [N-1:0] r;
        rst_i       = 1'b1;
        run_i       = 1'b0;
        flush_i     = 1'b0;
        stage_rdy_i = '0;
        #2;
        do_reset();

        // 1. Fixed rotation: start, then 12 running cycles = 3 retirements.
        step(1'b1, 4'b1111, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 4'b1111, 1'b0);
        check("rotation_cnt", 32'(retire_cnt_o), 32'd3);

        // 2. Wait states in stage 1.
        step(1'b1, 4'b1111, 1'b0);                       // -> stage 1
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1101, 1'b0);
        check("wait3", 32'(wait_cnt_o), 32'd3);
        step(1'b1, 4'b1111, 1'b0);                       // -> stage 2
        check("wait_clr", 32'(wait_cnt_o), 32'd0);
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);                       // retire -> stage 0

        // 4. Flush coincident with rdy in the last stage.
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b1);
        check("flush_cnt", 32'(retire_cnt_o), 32'd4);
        check("flush_first", 32'(stage_first_o), 32'd1);

        // 5. Halt boundary: run drops in stage 1.
        step(1'b1, 4'b1111, 1'b0);                       // -> stage 1
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 1'b0);
        check("halt_halted", 32'(halted_o), 32'd1);
        step(1'b0, 4'b1111, 1'b1);
        step(1'b0, 4'b1111, 1'b0);
        step(1'b1, 4'b0000, 1'b0);                       // restart at stage 0

        // Watchdog boundary: rdy in the last allowed cycle is accepted.
        for (int i = 0; i < MW; i++) step(1'b1, 4'b1110, 1'b0);
        check("wd_edge_wait", 32'(wait_cnt_o), 32'(MW));
        step(1'b1, 4'b0001, 1'b0);
        check("wd_edge_ok", 32'(timeout_o), 32'd0);

        // Random traffic; inactive rdy bits and rare flush / run drops.
        for (int i = 0; i < 300; i++) begin
            for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 9) != 0, r, $urandom_range(0, 19) == 0);
        end

        // 3. Watchdog trip in stage 2.
        do_reset();
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);                       // stage 2
        for (int i = 0; i < MW + 1; i++) step(1'b1, 4'b1011, 1'b0);
        check("wd_timeout", 32'(timeout_o), 32'd1);
        check("wd_en", 32'(stage_en_o), 32'd0);
        step(1'b1, 4'b1111, 1'b1);
        step(1'b0, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        check("wd_sticky", 32'(timeout_o), 32'd1);

        // 6. Counter wrap, then asynchronous reset in stage 2.
        do_reset();
        step(1'b1, 4'b1111, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b1, 4'b1111, 1'b0);
        check("cnt15", 32'(retire_cnt_o), 32'd15);
        for (int i = 0; i < 4; i++) step(1'b1, 4'b1111, 1'b0);
        check("cnt_wrap", 32'(retire_cnt_o), 32'd0);
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        check("pre_rst_stage", 32'(stage_o), 32'd2);
        #2;
        do_reset();
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
